detnotas: RTL and testbench
===========================

# detnotas

Tone detector: the receiving end of the note sequencer. Measures the period of an incoming square-wave tone on `ch_in` in `clk` cycles and classifies it against three configured note periods. Reports which note is playing, or silence. Sits behind a pin or loop-back from a sequencer channel output and feeds status LEDs or a higher-level melody checker.

## Interface
- `N0`, default 45867: period in `clk` cycles of note 0 (Do, 12 MHz).
- `N1`, default 40863: period of note 1 (Re).
- `N2`, default 36404: period of note 2 (Mi).
- `TOL`, default 256: accepted absolute deviation, |period − Nk| ≤ TOL.
- `TIMEOUT`, default 65535: cycles without a rising edge before declaring silence. Must satisfy Nk + TOL < TIMEOUT ≤ 2^W − 1.
- `W`, default 16: counter and period width.
- `clk` in 1: system clock.
- `rstn` in 1: asynchronous reset, active-low.
- `ch_in` in 1: tone input. Asynchronous to `clk`.
- `period` out W: last measured period in cycles.
- `valid` out 1: one-cycle pulse when `period` is updated.
- `note` out 2: stable note index 0..2, or 3 = none.
- `silence` out 1: high while no tone is present.

## Operation
- Input path:
  - 2-flop synchronizer, then a third flop `s3`.
  - `rise = s2 & ~s3`.
- Cycle counter `cnt` (W bits):
  - Loads 1 on `rise`.
  - Otherwise increments, saturating at 2^W − 1.
- FSM states: IDLE, ARMED, LOCKED.
  - IDLE: on `rise` → ARMED. No measurement is taken; `silence` is cleared on entry to ARMED.
  - ARMED or LOCKED: on `rise`, capture `period <= cnt`, pulse `valid`, classify `cnt`.
  - Classification: `cand` = first k in order 0, 1, 2 with |cnt − Nk| ≤ TOL, else 3. Comparison is on unsigned W+1-bit differences, with no wrap.
  - If `cand == last_cand` and `cand != 3`: `note <= cand`, state LOCKED.
  - If `cand == 3`, or `cand` differs from `last_cand`: `note <= 3`, state ARMED.
  - `last_cand <= cand` on every capture.
  - Any state, `cnt == TIMEOUT` with no `rise`: → IDLE, `note <= 3`, `silence <= 1`, `last_cand <= 3`.
- Simultaneous `rise` and timeout in the same cycle: `rise` wins. The measurement proceeds; no silence is declared.
- A glitch shorter than one `clk` may be missed. A pulse of one clean cycle or more produces exactly one `rise`.

## Timing
- Reset values: `period` = 0, `valid` = 0, `note` = 3, `silence` = 1, state IDLE, `cnt` = 0, `last_cand` = 3, synchronizer flops = 0.
- Latency from `ch_in` rising (setup met) to `rise`: 2 cycles. `period`, `valid` and `note` are registered 1 cycle later.
- For an ideal input of period P, `period` == P exactly.
- First `valid` occurs on the 2nd rising edge after silence. First non-3 `note` occurs on the 3rd rising edge.
- Timeout: `silence` asserts TIMEOUT+1 cycles after the last `rise`.
- Reset mid-operation:
  - All outputs return to reset values immediately, asynchronously.
  - If `ch_in` is high at reset release, a `rise` occurs 2 cycles later and only arms the detector.

## Structure
- Shared package holds:
  - `NOTE_NONE` = 2'd3.
  - The FSM state encoding (IDLE = 0, ARMED = 1, LOCKED = 2).
  - The default 12 MHz note periods, shared with the sequencer.
- One natural sub-module: `sync_rise`, the 3-flop synchronizer plus rising-edge detector, with ports `clk`, `rstn`, `d`, `rise`. It is reusable for the other asynchronous inputs.

## Test plan
Bench parameters: N0=4, N1=3, N2=2, TOL=0, TIMEOUT=16, W=5. Each expected response below must be checked after the stated stimulus.

- **Steady tone, note 0.** Stimulus: `ch_in` = period-4 square wave. Required: `valid` pulse every 4 cycles with `period` = 4; `note` = 0 from the 3rd edge on; `silence` = 0.
- **Note change.** Stimulus: switch period 3 → 2 mid-stream. Required: one capture shows `period` = 2 with `note` = 3; the next capture shows `note` = 2.
- **Unmatched period.** Stimulus: period-7 wave. Required: `period` = 7 on each `valid`; `note` stays 3; `silence` = 0.
- **Silence.** Stimulus: hold `ch_in` low after a period-4 tone. Required: `silence` = 1 and `note` = 3 exactly 17 cycles after the last `rise`. The next edge arms only, with no `valid`.
- **Collision.** Stimulus: a `rise` landing on the cycle `cnt` == 16. Required: a `valid` with `period` = 16; `silence` stays 0.
- **Reset mid-tone.** Stimulus: assert `rstn` low mid-tone while `note` = 0. Required: outputs go to reset values asynchronously. After release, `valid` does not assert until the 2nd `rise`.

Source files
------------

// File: rtl/detnotas_pkg.sv
// Shared definitions for the tone detector: note encoding, FSM states and the
// default 12 MHz note periods also used by the note sequencer.
package detnotas_pkg;

    localparam logic [1:0] NOTE_NONE = 2'd3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam int DEF_N0 = 45867;
    localparam int DEF_N1 = 40863;
    localparam int DEF_N2 = 36404;

endpackage

// File: rtl/detnotas_sync_rise.sv
// Two-flop synchronizer plus a third flop for rising-edge detection of an
// asynchronous input; rise is a one-cycle pulse per clean low-to-high change.
module sync_rise (
    input  logic clk,
    input  logic rstn,
    input  logic d,
    output logic rise
);

    logic s1_q;
    logic s2_q;
    logic s3_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= d;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign rise = s2_q & ~s3_q;

endmodule

// File: rtl/detnotas.sv
// Tone detector: measures the rise-to-rise period of ch_in in clk cycles and
// classifies it against three note periods, reporting a stable note or silence.
module detnotas
    import detnotas_pkg::*;
#(
    parameter int N0      = DEF_N0,
    parameter int N1      = DEF_N1,
    parameter int N2      = DEF_N2,
    parameter int TOL     = 256,
    parameter int TIMEOUT = 65535,
    parameter int W       = 16
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         ch_in,
    output logic [W-1:0] period,
    output logic         valid,
    output logic [1:0]   note,
    output logic         silence
);

    localparam logic [W-1:0] TIMEOUT_W = W'(TIMEOUT);

    logic         rise;
    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;
    state_t       state_q;
    logic [W-1:0] period_q;
    logic         valid_q;
    logic [1:0]   note_q;
    logic         silence_q;
    logic [1:0]   last_cand_q;
    logic [1:0]   cand;

    sync_rise u_sync (
        .clk  (clk),
        .rstn (rstn),
        .d    (ch_in),
        .rise (rise)
    );

    // Unsigned distance on W+1 bits so neither direction can wrap.
    function automatic logic in_tol(input logic [W-1:0] c, input int nk);
        logic [W:0] a;
        logic [W:0] b;
        logic [W:0] diff;
        a    = {1'b0, c};
        b    = (W+1)'(nk);
        diff = (a >= b) ? (a - b) : (b - a);
        return (diff <= (W+1)'(TOL));
    endfunction

    always_comb begin
        cand = NOTE_NONE;
        if (in_tol(cnt_q, N0)) begin
            cand = 2'd0;
        end else if (in_tol(cnt_q, N1)) begin
            cand = 2'd1;
        end else if (in_tol(cnt_q, N2)) begin
            cand = 2'd2;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (rise) begin
            cnt_d = W'(1);
        end else if (cnt_q != {W{1'b1}}) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    // A rise takes priority over a timeout landing in the same cycle.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            period_q    <= '0;
            valid_q     <= 1'b0;
            note_q      <= NOTE_NONE;
            silence_q   <= 1'b1;
            last_cand_q <= NOTE_NONE;
        end else begin
            cnt_q   <= cnt_d;
            valid_q <= 1'b0;
            if (rise) begin
                case (state_q)
                    IDLE: begin
                        state_q   <= ARMED;
                        silence_q <= 1'b0;
                    end
                    default: begin
                        period_q    <= cnt_q;
                        valid_q     <= 1'b1;
                        last_cand_q <= cand;
                        if ((cand == last_cand_q) && (cand != NOTE_NONE)) begin
                            note_q  <= cand;
                            state_q <= LOCKED;
                        end else begin
                            note_q  <= NOTE_NONE;
                            state_q <= ARMED;
                        end
                    end
                endcase
            end else if (cnt_q == TIMEOUT_W) begin
                state_q     <= IDLE;
                note_q      <= NOTE_NONE;
                silence_q   <= 1'b1;
                last_cand_q <= NOTE_NONE;
            end
        end
    end

    assign period  = period_q;
    assign valid   = valid_q;
    assign note    = note_q;
    assign silence = silence_q;

endmodule

// File: tb/tb_detnotas.sv
// Directed bench for detnotas with small note periods: table-driven tone
// sequences plus hand-written silence, collision and reset sequences.
module tb_detnotas;

    localparam int W = 5;

    logic         clk   = 1'b0;
    logic         rstn  = 1'b0;
    logic         ch_in = 1'b0;
    logic [W-1:0] period;
    logic         valid;
    logic [1:0]   note;
    logic         silence;

    detnotas #(
        .N0      (4),
        .N1      (3),
        .N2      (2),
        .TOL     (0),
        .TIMEOUT (16),
        .W       (W)
    ) dut (
        .clk     (clk),
        .rstn    (rstn),
        .ch_in   (ch_in),
        .period  (period),
        .valid   (valid),
        .note    (note),
        .silence (silence)
    );

    always #5 clk = ~clk;

    // One record per ch_in rising edge: p is the interval to the next rise;
    // expectations describe the capture that this rise causes.
    typedef struct {
        int           p;
        bit           ev;
        logic [W-1:0] eper;
        logic [1:0]   enote;
        bit           esil;
    } vec_t;

    int   checks        = 0;
    int   failures      = 0;
    int   cyc           = 0;
    int   last_rise_cyc = 0;
    int   tgt_q[$];
    int   id_q[$];
    vec_t exp_q[$];
    vec_t tab1[16];
    vec_t tab2[6];

    function automatic vec_t mk(input int p, input bit ev, input int eper, input int enote);
        vec_t v;
        v.p     = p;
        v.ev    = ev;
        v.eper  = W'(eper);
        v.enote = 2'(enote);
        v.esil  = 1'b0;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%0d required=%0d", name, cyc, act, req);
        end else begin
            $display("ok   %s cyc=%0d value=%0d", name, cyc, act);
        end
    endtask

    task automatic do_checks();
        vec_t v;
        int   id;
        int   t;
        if (tgt_q.size() > 0 && tgt_q[0] == cyc) begin
            t  = tgt_q.pop_front();
            v  = exp_q.pop_front();
            id = id_q.pop_front();
            check($sformatf("v%0d.valid", id), 32'(valid), 32'(v.ev));
            if (v.ev) check($sformatf("v%0d.period", id), 32'(period), 32'(v.eper));
            check($sformatf("v%0d.note", id), 32'(note), 32'(v.enote));
            check($sformatf("v%0d.silence", id), 32'(silence), 32'(v.esil));
        end else if (valid !== 1'b0) begin
            check("unexpected_valid", 32'(valid), 32'd0);
        end
    endtask

    task automatic cycle(input logic v);
        ch_in = v;
        @(negedge clk);
        cyc++;
        do_checks();
    endtask

    task automatic expect_at(input int id, input vec_t v);
        tgt_q.push_back(cyc + 3);
        exp_q.push_back(v);
        id_q.push_back(id);
    endtask

    task automatic wave(input int id, input vec_t v);
        int h;
        h = (v.p / 2 < 1) ? 1 : v.p / 2;
        last_rise_cyc = cyc;
        expect_at(id, v);
        for (int i = 0; i < v.p; i++) cycle(i < h);
    endtask

    initial begin
        // Steady note 0, change 0->1->2, unmatched 7, then relock on note 0.
        tab1[0]  = mk(4, 1'b0, 0, 3);
        tab1[1]  = mk(4, 1'b1, 4, 3);
        tab1[2]  = mk(4, 1'b1, 4, 0);
        tab1[3]  = mk(4, 1'b1, 4, 0);
        tab1[4]  = mk(3, 1'b1, 4, 0);
        tab1[5]  = mk(3, 1'b1, 3, 3);
        tab1[6]  = mk(3, 1'b1, 3, 1);
        tab1[7]  = mk(2, 1'b1, 3, 1);
        tab1[8]  = mk(2, 1'b1, 2, 3);
        tab1[9]  = mk(2, 1'b1, 2, 2);
        tab1[10] = mk(7, 1'b1, 2, 2);
        tab1[11] = mk(7, 1'b1, 7, 3);
        tab1[12] = mk(7, 1'b1, 7, 3);
        tab1[13] = mk(4, 1'b1, 7, 3);
        tab1[14] = mk(4, 1'b1, 4, 3);
        tab1[15] = mk(4, 1'b1, 4, 0);
        // After silence: arm only, then a 16-cycle interval colliding with timeout.
        tab2[0]  = mk(4,  1'b0, 0,  3);
        tab2[1]  = mk(16, 1'b1, 4,  3);
        tab2[2]  = mk(4,  1'b1, 16, 3);
        tab2[3]  = mk(4,  1'b1, 4,  3);
        tab2[4]  = mk(4,  1'b1, 4,  0);
        tab2[5]  = mk(4,  1'b1, 4,  0);

        repeat (3) @(negedge clk);
        check("reset.period",  32'(period),  32'd0);
        check("reset.valid",   32'(valid),   32'd0);
        check("reset.note",    32'(note),    32'd3);
        check("reset.silence", 32'(silence), 32'd1);
        rstn = 1'b1;
        repeat (20) cycle(1'b0);

        for (int i = 0; i < 16; i++) wave(i, tab1[i]);

        while (cyc < last_rise_cyc + 18) cycle(1'b0);
        check("pre_timeout.silence", 32'(silence), 32'd0);
        check("pre_timeout.note",    32'(note),    32'd0);
        cycle(1'b0);
        check("timeout.silence", 32'(silence), 32'd1);
        check("timeout.note",    32'(note),    32'd3);
        repeat (3) cycle(1'b0);

        for (int i = 0; i < 6; i++) wave(100 + i, tab2[i]);

        // Reset in the middle of a locked tone, with ch_in held high across release.
        cycle(1'b1);
        check("pre_reset.note", 32'(note), 32'd0);
        #2;
        rstn = 1'b0;
        #1;
        check("async_reset.period",  32'(period),  32'd0);
        check("async_reset.valid",   32'(valid),   32'd0);
        check("async_reset.note",    32'(note),    32'd3);
        check("async_reset.silence", 32'(silence), 32'd1);
        @(negedge clk);
        cyc++;
        do_checks();
        #2;
        rstn = 1'b1;
        expect_at(199, mk(4, 1'b0, 0, 3));
        cycle(1'b1);
        cycle(1'b1);
        cycle(1'b0);
        cycle(1'b0);
        wave(200, mk(4, 1'b1, 4, 3));
        wave(201, mk(4, 1'b1, 4, 0));
        repeat (4) cycle(1'b0);
        check("pending_empty", 32'(tgt_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
